// File: rtl/shiyan1_full_adder_pkg.sv
// Shared defaults and the bit-cell carry function for the shiyan1 adder slice.
package shiyan1_full_adder_pkg;

    localparam int DEF_WIDTH   = 1;
    localparam bit DEF_REG_OUT = 1'b1;

    // Majority of three inputs: the carry-out of a single full-adder bit.
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/shiyan1_fa_cell.sv
// One-bit full adder cell; chained by the top to form a ripple-carry adder.
module shiyan1_fa_cell
    import shiyan1_full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is the three-way parity, carry is the majority.
    always_comb begin
        s  = a ^ b ^ ci;
        co = fa_carry(a, b, ci);
    end

endmodule

// File: rtl/shiyan1_full_adder.sv
// Ripple-carry adder {C1,F} = A + B + C with an optional output register.
// WIDTH=1 reduces to the plain 1-bit full adder.
module shiyan1_full_adder
    import shiyan1_full_adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter bit REG_OUT = DEF_REG_OUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic [WIDTH-1:0] F,
    output logic             C1
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;

    assign carry[0] = C;

    // Carry ripples from bit 0 upward; carry[WIDTH] is the carry-out.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        shiyan1_fa_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum_d[i]),
            .co (carry[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             co_q;

        // Capture the adder result every cycle; reset clears it without a clock.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q <= '0;
                co_q  <= 1'b0;
            end else begin
                sum_q <= sum_d;
                co_q  <= carry[WIDTH];
            end
        end

        assign F  = sum_q;
        assign C1 = co_q;
    end else begin : g_comb
        // Clock and reset have no role in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign F  = sum_d;
        assign C1 = carry[WIDTH];
    end

endmodule

// File: tb/tb_shiyan1_full_adder.sv
// Scoreboard bench for shiyan1_full_adder: registered and combinational 1-bit
// builds, an 8-bit boundary build and a 16-bit random build.
`timescale 1ns/1ps
module tb_shiyan1_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #50 clk = ~clk;   // 100 ns per vector

    // 1-bit registered
    logic a1, b1, c1, f1, co1;
    // 1-bit combinational
    logic a0, b0, c0, f0, co0;
    // 8-bit registered
    logic [7:0] a8, b8, f8;
    logic c8, co8;
    // 16-bit registered
    logic [15:0] a16, b16, f16;
    logic c16, co16;

    shiyan1_full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1r (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .C(c1), .F(f1), .C1(co1));
    shiyan1_full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_w1c (
        .clk(clk), .rst(rst), .A(a0), .B(b0), .C(c0), .F(f0), .C1(co0));
    shiyan1_full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .C(c8), .F(f8), .C1(co8));
    shiyan1_full_adder #(.WIDTH(16), .REG_OUT(1'b1)) u_w16r (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .C(c16), .F(f16), .C1(co16));

    int n_chk  = 0;
    int n_fail = 0;

    // Expected {carry,sum}, pushed when stimulus is driven, popped after the edge.
    logic [16:0] sb_q[$];

    // Truth table indexed by {A,B,C}.
    logic [7:0] tt_f  = 8'b1001_0110;
    logic [7:0] tt_co = 8'b1110_1000;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        logic [16:0] exp_v;
        logic [16:0] prev_v;
        logic [2:0]  abc;

        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a0 = 1'b0; b0 = 1'b0; c0 = 1'b0;
        a8 = '0;   b8 = '0;   c8 = 1'b0;
        a16 = '0;  b16 = '0;  c16 = 1'b0;

        // Reset applies before any clock edge and holds across edges.
        #1 rst = 1'b1;
        #1;
        chk("rst_async_w1", {co1, f1}, 2'b00);
        chk("rst_async_w8", {co8, f8}, 9'h000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_w1", {co1, f1}, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive 1-bit walk, registered build: result appears one edge later.
        prev_v = '0;
        for (int v = 0; v < 8; v++) begin
            abc = 3'(v);
            {a1, b1, c1} = abc;
            sb_q.push_back({15'd0, tt_co[v], tt_f[v]});
            #1;
            chk("w1_latency", {co1, f1}, prev_v[1:0]);
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            chk($sformatf("w1_walk_%0d", v), {co1, f1}, exp_v[1:0]);
            prev_v = exp_v;
            @(negedge clk);
        end

        // Same walk, combinational build: settles without a clock.
        for (int v = 0; v < 8; v++) begin
            abc = 3'(v);
            {a0, b0, c0} = abc;
            #1;
            chk($sformatf("w1c_walk_%0d", v), {co0, f0}, {tt_co[v], tt_f[v]});
        end

        // 8-bit boundaries.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            case (k)
                0: begin a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; sb_q.push_back({8'd0, 1'b1, 8'h00}); end
                1: begin a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; sb_q.push_back({8'd0, 1'b1, 8'hFF}); end
                2: begin a8 = 8'h3C; b8 = 8'h05; c8 = 1'b0; sb_q.push_back({8'd0, 1'b0, 8'h41}); end
                default: begin a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; sb_q.push_back({8'd0, 1'b0, 8'h00}); end
            endcase
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            chk($sformatf("w8_bound_%0d", k), {co8, f8}, exp_v[8:0]);
        end

        // Mid-stream reset: outputs drop at once, next edge reloads.
        @(negedge clk);
        {a1, b1, c1} = 3'b111;
        @(posedge clk);
        #1;
        chk("mid_pre", {co1, f1}, 2'b11);
        #10 rst = 1'b1;
        #1;
        chk("mid_rst_drop", {co1, f1}, 2'b00);
        #5 rst = 1'b0;
        #1;
        chk("mid_rst_hold", {co1, f1}, 2'b00);
        @(posedge clk);
        #1;
        chk("mid_reload", {co1, f1}, 2'b11);

        // Random 16-bit against an integer reference.
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            sb_q.push_back(17'(a16) + 17'(b16) + 17'(c16));
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            chk("w16_rand", {co16, f16}, exp_v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
